// File: rtl/truth_table_checker.sv
// Response monitor for a 4-input combinational DUT. It samples f once per settled stimulus
// vector, checks f against a 16-entry truth table, and tracks coverage, errors and the first failure.
module truth_table_checker #(
  parameter logic [15:0] EXPECT = 16'h6996,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        w,
  input  logic        x,
  input  logic        y,
  input  logic        z,
  input  logic        f,
  output logic        sample_valid,
  output logic        mismatch,
  output logic [15:0] seen,
  output logic [4:0]  err_cnt,
  output logic        first_bad_valid,
  output logic [3:0]  first_bad_vec,
  output logic        done,
  output logic        pass
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  logic [1:0]  state_reg;
  logic [3:0]  vec_q_reg;
  logic [3:0]  settle_cnt_reg;
  logic        sampled_flag_reg;
  logic        sample_valid_reg;
  logic        mismatch_reg;
  logic [15:0] seen_reg;
  logic [4:0]  err_cnt_reg;
  logic        first_bad_valid_reg;
  logic [3:0]  first_bad_vec_reg;

  logic [3:0]  vec;
  logic        restart;
  logic [3:0]  settle_cnt_next;
  logic        sampled_flag_next;
  logic        fire;
  logic        bad;
  logic [15:0] seen_next;

  assign vec = {w, x, y, z};

  // The first enabled edge and every vector change both start a fresh settle window.
  assign restart           = (state_reg == ST_IDLE) || (vec != vec_q_reg);
  assign settle_cnt_next   = restart ? 4'd1
                           : ((settle_cnt_reg == 4'd15) ? 4'd15 : settle_cnt_reg + 4'd1);
  assign sampled_flag_next = restart ? 1'b0 : sampled_flag_reg;
  assign fire              = en && (state_reg != ST_DONE)
                           && (settle_cnt_next == SETTLE_CNT) && !sampled_flag_next;
  assign bad               = (f != EXPECT[vec]);
  assign seen_next         = seen_reg | (16'd1 << vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= ST_IDLE;
      vec_q_reg           <= 4'd0;
      settle_cnt_reg      <= 4'd0;
      sampled_flag_reg    <= 1'b0;
      sample_valid_reg    <= 1'b0;
      mismatch_reg        <= 1'b0;
      seen_reg            <= 16'd0;
      err_cnt_reg         <= 5'd0;
      first_bad_valid_reg <= 1'b0;
      first_bad_vec_reg   <= 4'd0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (state_reg != ST_DONE) begin
        if (!en) begin
          // A vector held across an enable-low period is checked again once enable returns.
          settle_cnt_reg   <= 4'd0;
          sampled_flag_reg <= 1'b0;
        end else begin
          state_reg        <= ST_SETTLE;
          vec_q_reg        <= vec;
          settle_cnt_reg   <= settle_cnt_next;
          sampled_flag_reg <= sampled_flag_next | fire;
          if (fire) begin
            sample_valid_reg <= 1'b1;
            mismatch_reg     <= bad;
            seen_reg         <= seen_next;
            if (bad && (err_cnt_reg != 5'd31))
              err_cnt_reg <= err_cnt_reg + 5'd1;
            if (bad && !first_bad_valid_reg) begin
              first_bad_valid_reg <= 1'b1;
              first_bad_vec_reg   <= vec;
            end
            if (&seen_next)
              state_reg <= ST_DONE;
          end
        end
      end
    end
  end

  assign sample_valid    = sample_valid_reg;
  assign mismatch        = mismatch_reg;
  assign seen            = seen_reg;
  assign err_cnt         = err_cnt_reg;
  assign first_bad_valid = first_bad_valid_reg;
  assign first_bad_vec   = first_bad_vec_reg;
  assign done            = (state_reg == ST_DONE);
  assign pass            = (state_reg == ST_DONE) && (err_cnt_reg == 5'd0);

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking response monitor for 4-input combinational functions under exhaustive test. It sits opposite the stimulus driver on the bench-side DUT interface. It watches the applied vector {w,x,y,z} and the DUT output f, and waits for each new vector to settle. It then samples f exactly once and compares it against a parameterised 16-entry truth table. It tracks minterm coverage, counts mismatches, captures the first failing vector, and flags done/pass once all 16 minterms have been checked.

## Interface

Parameters:
- EXPECT, 16'h6996, expected truth table; bit index = {w,x,y,z}. Default is 4-input odd parity.
- SETTLE, 2, consecutive stable clock edges required before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  checking enable; low freezes all checking state.
- w, x, y, z  input  1 each  applied stimulus vector; w is the MSB.
- f  input  1  DUT response.
- sample_valid  output  1  one-cycle pulse marking a completed sample.
- mismatch  output  1  registered result of the last sample; 1 means f differed from the expected bit.
- seen  output  16  coverage map; bit i set once minterm i has been sampled.
- err_cnt  output  5  mismatch count; saturates at 31.
- first_bad_valid  output  1  set by the first mismatch.
- first_bad_vec  output  4  vector of the first mismatch.
- done  output  1  all 16 minterms sampled.
- pass  output  1  done && err_cnt == 0.

## Operation

- Internal signals: vec = {w,x,y,z}; vec_q = vec registered every enabled edge; settle_cnt is 4 bits; sampled_flag.
- Reset values: all outputs 0; vec_q, settle_cnt and sampled_flag are 0; state is IDLE.
- FSM states:
  - IDLE: on the first edge with en=1, load vec_q←vec and settle_cnt←1, then go to SETTLE.
  - SETTLE:
    - Change edge (vec != vec_q): vec_q←vec, settle_cnt←1, sampled_flag←0.
    - Stable edge: settle_cnt increments, saturating at 15.
    - Sample fire: on the edge where settle_cnt reaches SETTLE with sampled_flag=0, perform the sample actions and set sampled_flag←1.
  - DONE: entered on the edge where seen becomes all ones. All outputs hold; inputs are ignored until rst.
- Sample actions, all on one edge:
  - sample_valid←1 for one cycle.
  - mismatch←(f != EXPECT[vec]).
  - seen[vec]←1.
  - On mismatch: err_cnt←err_cnt+1, saturating at 31.
  - On mismatch with first_bad_valid=0: first_bad_vec←vec and first_bad_valid←1.
- A stable vector is sampled once only. Re-applying a vector after a change samples it again: seen is unchanged and errors count again.
- The vector is compared against vec at the sample edge. f is sampled at the same edge.
- en=0: no state changes and no sample_valid. settle_cnt←0 and sampled_flag←0, so a vector held across an en-low period is resampled after SETTLE edges with en high.
- Simultaneous cases:
  - A vector change on the would-be sample edge counts as a change: no sample.
  - The 16th new minterm sample and the transition to DONE occur on the same edge. done and pass are visible together with that sample_valid.
- rst mid-run clears everything, including seen and err_cnt, on the next edge.

## Timing

- Latency: a vector first present at edge k (the change edge) is sampled at edge k+SETTLE-1. Results are visible in the cycle after that edge.
- SETTLE=1 samples on the change edge itself.
- Throughput: at most one sample per distinct stable vector. A vector must be held for at least SETTLE edges to be checked; shorter glitches are never sampled.
- done, pass, first_bad_* and seen are level outputs. sample_valid is the only pulse.

## Test plan

- Reset, then the exhaustive sweep 0000→1111 with f = w^x^y^z and each vector held 5 clocks, SETTLE=2: expect 16 sample_valid pulses and seen=16'hFFFF. done=1 and pass=1 appear on the 16th sample, with err_cnt=0.
- Same sweep with f forced to 0 for vectors 0111 and 1011: expect err_cnt=2, first_bad_vec=4'b0111, first_bad_valid=1, done=1, pass=0.
- 1-cycle glitch to 1111 between held vectors, SETTLE=2: no sample of 1111, seen[15]=0, and no err_cnt change.
- en held low for 10 cycles mid-sweep while the vector is stable: no pulses and counts frozen. After en rises, the held vector is sampled exactly once, 2 edges later.
- rst asserted after 8 vectors: the next cycle shows seen=0, err_cnt=0, done=0. A full sweep then completes normally.
- 40 mismatching samples, by toggling the vector between 0000 and 0001 with f=1: err_cnt saturates at 31 and first_bad_vec=4'b0000.
